// File: rtl/step_counter_pkg.sv
// Shared types and parameter-legality helper for the step_counter family.
// Optional feature macro used by step_counter: COUNTER_PRESCALE_EN.
package counter_pkg;

  typedef enum logic {
    CNT_DOWN = 1'b0,
    CNT_UP   = 1'b1
  } cnt_dir_e;

  typedef enum logic {
    CNT_WRAP = 1'b0,
    CNT_SAT  = 1'b1
  } cnt_mode_e;

  localparam int unsigned CNT_MAX_WIDTH = 64;

  // True when WIDTH, MAX and STEP describe a buildable counter.
  function automatic bit params_ok(input int unsigned     width,
                                   input longint unsigned max,
                                   input longint unsigned step);
    logic [64:0] limit;
    limit = (65'd1 << width) - 65'd1;
    return (width >= 2) && (width <= CNT_MAX_WIDTH) &&
           (step >= 1) && (step <= max) &&
           ({1'b0, max} <= limit);
  endfunction

endpackage

// File: rtl/step_counter_if.sv
// Control/status bundle between a counter user (master) and step_counter (slave).
interface step_counter_if #(
  parameter int unsigned WIDTH = 32
);
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             up_dn;
  logic             sat_mode;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             ovf;

  modport master (
    output clear, load, load_val, en, up_dn, sat_mode,
    input  q, tc, ovf
  );

  modport slave (
    input  clear, load, load_val, en, up_dn, sat_mode,
    output q, tc, ovf
  );
endinterface

// File: rtl/step_counter_prescaler.sv
// count_prescaler: divides the count enable by PRESCALE; tick marks the last
// enabled cycle of each window. en low freezes the window position.
module count_prescaler #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic restart,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_r;

  assign tick = (cnt_r == LAST);

  // Window position: restarts on clear/load, advances only on enabled cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= '0;
    end else if (restart) begin
      cnt_r <= '0;
    end else if (en) begin
      cnt_r <= tick ? '0 : cnt_r + CW'(1);
    end
  end

endmodule

// File: rtl/step_counter.sv
// step_counter: WIDTH-bit up/down counter with programmable step and modulus,
// synchronous clear/load, wrap-or-saturate and registered tc/ovf.
// Optional enable prescaler selected by defining COUNTER_PRESCALE_EN.
module step_counter
  import counter_pkg::*;
#(
  parameter int unsigned     WIDTH    = 32,
  parameter longint unsigned MAX      = (64'd1 << WIDTH) - 64'd1,
  parameter longint unsigned STEP     = 1,
  parameter int unsigned     PRESCALE = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  step_counter_if.slave bus
);

  if (!params_ok(WIDTH, MAX, STEP) || (PRESCALE < 1)) begin : g_bad_params
    $error("step_counter: illegal WIDTH/MAX/STEP/PRESCALE combination");
  end

  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] STEP_V = WIDTH'(STEP);

  logic [WIDTH-1:0] q_r, q_nxt;
  logic             tc_r, tc_nxt;
  logic             ovf_r, ovf_nxt;
  logic             tick;
  logic [WIDTH:0]   sum_up;
  logic [WIDTH-1:0] wrap_up, wrap_dn, diff_dn;
  cnt_dir_e         dir;
  cnt_mode_e        mode;

  assign dir  = cnt_dir_e'(bus.up_dn);
  assign mode = cnt_mode_e'(bus.sat_mode);

`ifdef COUNTER_PRESCALE_EN
  count_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .restart (bus.clear | bus.load),
    .en      (bus.en),
    .tick    (tick)
  );
`else
  assign tick = 1'b1;
`endif

  // Candidate next values; wrap results are taken modulo 2**WIDTH, which is
  // exact because the true wrapped value always lies within 0..MAX.
  assign sum_up  = {1'b0, q_r} + {1'b0, STEP_V};
  assign wrap_up = q_r + STEP_V - MAX_V - WIDTH'(1);
  assign wrap_dn = q_r + MAX_V - STEP_V + WIDTH'(1);
  assign diff_dn = q_r - STEP_V;

  // Next-state: clear > load > count > hold.
  always_comb begin
    q_nxt   = q_r;
    tc_nxt  = 1'b0;
    ovf_nxt = ovf_r;
    if (bus.clear) begin
      q_nxt   = '0;
      ovf_nxt = 1'b0;
    end else if (bus.load) begin
      q_nxt = (bus.load_val > MAX_V) ? MAX_V : bus.load_val;
    end else if (bus.en && tick) begin
      if (dir == CNT_UP) begin
        if (sum_up <= {1'b0, MAX_V}) begin
          q_nxt  = sum_up[WIDTH-1:0];
          tc_nxt = (sum_up == {1'b0, MAX_V});
        end else begin
          q_nxt   = (mode == CNT_SAT) ? MAX_V : wrap_up;
          tc_nxt  = 1'b1;
          ovf_nxt = 1'b1;
        end
      end else begin
        if (q_r >= STEP_V) begin
          q_nxt  = diff_dn;
          tc_nxt = (diff_dn == '0);
        end else begin
          q_nxt   = (mode == CNT_SAT) ? '0 : wrap_dn;
          tc_nxt  = 1'b1;
          ovf_nxt = 1'b1;
        end
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_r   <= '0;
      tc_r  <= 1'b0;
      ovf_r <= 1'b0;
    end else begin
      q_r   <= q_nxt;
      tc_r  <= tc_nxt;
      ovf_r <= ovf_nxt;
    end
  end

  assign bus.q   = q_r;
  assign bus.tc  = tc_r;
  assign bus.ovf = ovf_r;

endmodule

// File: doc/step_counter.md
# step_counter

Parametrised successor to the free-running incrementing flip-flop: a WIDTH-bit up/down counter with programmable step, modulus, synchronous load/clear, wrap-or-saturate mode and a registered terminal-count pulse. Used as the general-purpose event/timer counter in the datapath and as the reference DUT for counter benches. Single clock domain, no handshake; all control inputs sampled on the rising edge.

## Interface
- WIDTH, 32: counter width in bits (2..64).
- MAX, 2**WIDTH-1: highest legal count value; modulus is MAX+1.
- STEP, 1: increment/decrement per counting edge (1..MAX).
- PRESCALE, 4: enable divider ratio, used only with COUNTER_PRESCALE_EN (≥1).
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous clear of q and ovf.
- load  input  1  synchronous load of load_val.
- load_val  input  WIDTH  value for load; values above MAX clamp to MAX.
- en  input  1  count enable.
- up_dn  input  1  1 = count up, 0 = count down.
- sat_mode  input  1  1 = saturate at bounds, 0 = wrap modulo MAX+1.
- q  output  WIDTH  current count.
- tc  output  1  one-cycle pulse when a count crosses or reaches a bound.
- ovf  output  1  sticky: set on any wrap or saturation event.

## Operation
- Reset (reset_n low, any time, async): q=0, tc=0, ovf=0, prescaler count=0. Outputs hold these values until the first rising edge with reset_n high.
- Priority per edge: clear > load > count > hold.
- clear: q←0, ovf←0, tc←0; prescaler restarts.
- load: q←min(load_val, MAX), tc←0, ovf unchanged; prescaler restarts.
- Count edge = en && tick (tick=1 always without prescaler).
- Up: sum = q+STEP computed at WIDTH+1 bits. If sum ≤ MAX: q←sum, tc←(sum==MAX). Else wrap: q←sum-(MAX+1); saturate: q←MAX. Either way tc←1, ovf←1.
- Down: if q ≥ STEP: q←q-STEP, tc←(q-STEP==0). Else wrap: q←q+(MAX+1)-STEP; saturate: q←0. Either way tc←1, ovf←1.
- Saturated and holding at a bound: further counts in that direction keep q, pulse tc every count edge, ovf stays 1.
- No count edge: q holds, tc←0.
- up_dn and sat_mode may change on any cycle; they take effect on the next count edge.

## Timing
- Latency: q, tc, ovf update on the same rising edge that samples the control inputs; visible one cycle after inputs are driven.
- tc is registered, high for exactly one cycle per qualifying count edge; back-to-back count edges at a bound give a continuous tc.
- No combinational path from inputs to outputs.

## Configuration
- COUNTER_PRESCALE_EN defined: an internal prescaler counts en-high cycles 0..PRESCALE-1; tick=1 only on the cycle it equals PRESCALE-1 (then it restarts). Counter therefore advances once per PRESCALE enabled cycles. en low freezes the prescaler. PRESCALE=1 is identical to undefined behaviour.
- Undefined: no prescaler logic; tick tied high; PRESCALE ignored.

## Structure
- Shared package counter_pkg: typedef for direction (CNT_DOWN=0, CNT_UP=1) and mode (CNT_WRAP=0, CNT_SAT=1) enums, and parameter-legality checks as a function usable in elaboration-time assertions (STEP≤MAX, MAX<2**WIDTH).
- One sub-module: count_prescaler (PRESCALE parameter; clk, reset_n, restart, en in; tick out), instantiated only under COUNTER_PRESCALE_EN.

## Test plan
- Reset mid-count: count to 7, assert reset_n low between edges -> q=0, tc=0, ovf=0 immediately, without waiting for clk.
- Wrap up, WIDTH=8 MAX=9 STEP=3: count up from 0 -> q 3,6,9 (tc=1 at 9),2 (tc=1, ovf=1).
- Saturate down, sat_mode=1, STEP=3, load 4: count -> q 1, then 0 with tc=1, ovf=1; further count edges hold q=0, tc high each edge.
- Priority: clear, load=1 load_val=5, en=1 on same edge -> q=0, ovf=0; then load alone with load_val=200, MAX=9 -> q=9.
- Direction change: MAX=255 STEP=1, q=255 up then up_dn=0 next edge -> q 0 (tc, ovf), then 255 (tc); ovf stays 1 until clear.
- Prescaler (COUNTER_PRESCALE_EN, PRESCALE=4): en high 12 cycles from q=0 -> q increments on cycles 4, 8, 12 only; dropping en for 2 cycles mid-window delays the next increment by 2 cycles.
